// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and lane helpers for mem_port_arbiter.
// Lane 0 is the most significant byte of a word.
package mem_arb_pkg;

    typedef logic [0:3][7:0] byte_lanes_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    function automatic logic [31:0] lanes_to_word(byte_lanes_t l);
        return {l[0], l[1], l[2], l[3]};
    endfunction

    function automatic byte_lanes_t word_to_lanes(logic [31:0] w);
        byte_lanes_t l;
        l[0] = w[31:24];
        l[1] = w[23:16];
        l[2] = w[15:8];
        l[3] = w[7:0];
        return l;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals.
// slave = arbiter view, master = requesters plus memory model.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    byte_lanes_t d_wdata;
    byte_lanes_t d_rdata;
    logic        d_valid;

    logic [31:0] mem_addr;
    byte_lanes_t mem_data_in;
    logic        mem_write_en;
    byte_lanes_t mem_data_out;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output if_rdata, if_valid, d_rdata, d_valid,
        output mem_addr, mem_data_in, mem_write_en
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  if_rdata, if_valid, d_rdata, d_valid,
        input  mem_addr, mem_data_in, mem_write_en
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select between fetch and data.
// Data wins ties unless fetch has reached its starvation limit.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       starved,
    output logic       grant,
    output arb_owner_t owner
);

    // Any request grants; fetch only wins alone or when starved
    always_comb begin
        grant = if_req | d_req;
        owner = OWN_D;
        unique case (1'b1)
            (if_req && (!d_req || starved)): owner = OWN_IF;
            default:                         owner = OWN_D;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-lane memory between fetch and load/store.
// `define ARB_PERF_EN adds saturating grant/conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               halted,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
`ifdef ARB_PERF_EN
    ,
    output logic [15:0]        perf_if_grants,
    output logic [15:0]        perf_d_grants,
    output logic [15:0]        perf_conflicts
`endif
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_TOP    = CW'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state;
    arb_owner_t    owner;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve_cnt;
    logic [31:0]   addr_q;
    byte_lanes_t   wdata_q;
    byte_lanes_t   rdata_q;
    logic          mem_we_q;
    logic          if_valid_q;
    logic          d_valid_q;
    logic          busy_q;

    logic          grant;
    arb_owner_t    pick_owner;
    logic          take;
    logic [31:0]   sel_addr;
    byte_lanes_t   sel_wdata;
    logic          sel_we;

    mem_arb_pick u_pick (
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .starved (starve_cnt == STARVE_MAX),
        .grant   (grant),
        .owner   (pick_owner)
    );

    assign take = (state == IDLE) && !halted && grant;

    // Request fields of whichever port is about to win
    always_comb begin
        sel_addr  = bus.if_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (pick_owner == OWN_D) begin
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            sel_we    = bus.d_we;
        end
    end

    // Access sequencer IDLE -> ACCESS -> RESP with registered outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        state    <= ACCESS;
                        owner    <= pick_owner;
                        cnt      <= CNT_TOP;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        mem_we_q <= sel_we;
                        busy_q   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        rdata_q    <= bus.mem_data_out;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        if_valid_q <= (owner == OWN_IF);
                        d_valid_q  <= (owner == OWN_D);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch starvation: count data wins over a waiting fetch
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            starve_cnt <= '0;
        end else if (take) begin
            if (pick_owner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (bus.if_req && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`ifdef ARB_PERF_EN
    // Saturating grant and conflict counters
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (take && pick_owner == OWN_IF && perf_if_grants != 16'hFFFF)
                perf_if_grants <= perf_if_grants + 16'd1;
            if (take && pick_owner == OWN_D && perf_d_grants != 16'hFFFF)
                perf_d_grants <= perf_d_grants + 16'd1;
            if (state == IDLE && !halted && bus.if_req && bus.d_req &&
                perf_conflicts != 16'hFFFF)
                perf_conflicts <= perf_conflicts + 16'd1;
        end
    end
`endif

    assign bus.if_rdata     = lanes_to_word(rdata_q);
    assign bus.d_rdata      = rdata_q;
    assign bus.if_valid     = if_valid_q;
    assign bus.d_valid      = d_valid_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_in  = wdata_q;
    assign bus.mem_write_en = mem_we_q;
    assign busy             = busy_q;

    // Requesters must hold req and request fields until their valid
    a_if_hold: assert property (
        @(posedge clk) disable iff (!rst_b || halted)
        (bus.if_req && !bus.if_valid) |=>
        (bus.if_req && $stable(bus.if_addr))
    );

    a_d_hold: assert property (
        @(posedge clk) disable iff (!rst_b || halted)
        (bus.d_req && !bus.d_valid) |=>
        (bus.d_req && $stable(bus.d_addr) &&
         $stable(bus.d_we) && $stable(bus.d_wdata))
    );

endmodule
